// File: rtl/chacha_stream_adapter.sv
// chacha_stream_adapter
//
// AXI-Stream front end for a chacha_many core array. Input words are packed
// into a NUMBER_OF_BLOCKS*512-bit block, which is then handed to the core with
// a one-cycle chacha_next_block pulse. When the core reports a valid result,
// the block is streamed back out as 32-bit words. Short final blocks are
// zero-padded, and the padding words are never emitted. TLAST is carried from
// the input frame to the output frame.
//
// Optional feature: define CHACHA_STREAM_BYTESWAP_EN to byte-reverse every word
// on its way into chacha_data_in and on its way out of chacha_data_out. This
// converts between a big-endian host stream and the core's little-endian words.
//
// Ports:
//   clk, reset                      single clock, synchronous active-high reset
//   s_axis_tdata/tvalid/tready/tlast  plaintext input stream
//   m_axis_tdata/tvalid/tready/tlast  ciphertext output stream
//   chacha_data_in                  packed block to the core
//   chacha_next_block               one-cycle start pulse to the core
//   chacha_data_out                 core result
//   chacha_data_valid               core result valid
//   blocks_done                     completed transaction count (wraps)

module chacha_stream_adapter #(
    parameter int unsigned NUMBER_OF_BLOCKS = 1,
    parameter int unsigned TOTAL_BIT_WIDTH  = NUMBER_OF_BLOCKS * 512
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic [31:0]                s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tlast,

    output logic [31:0]                m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,

    output logic [TOTAL_BIT_WIDTH-1:0] chacha_data_in,
    output logic                       chacha_next_block,
    input  logic [TOTAL_BIT_WIDTH-1:0] chacha_data_out,
    input  logic                       chacha_data_valid,

    output logic [31:0]                blocks_done
);

    localparam int NW = NUMBER_OF_BLOCKS * 16;
    localparam int CW = $clog2(NW) + 1;

    typedef enum logic [2:0] {
        StFill,
        StStart,
        StArm,
        StWait,
        StDrain
    } state_e;

    function automatic logic [31:0] swap_word(input logic [31:0] w);
`ifdef CHACHA_STREAM_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    state_e                     state_q, state_d;
    logic [CW-1:0]              wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]              rd_cnt_q, rd_cnt_d;
    logic [CW-1:0]              len_q, len_d;
    logic                       frame_last_q, frame_last_d;
    logic [1:0]                 arm_cnt_q, arm_cnt_d;
    logic [TOTAL_BIT_WIDTH-1:0] data_q, data_d;
    logic [31:0]                blocks_q, blocks_d;
    logic [31:0]                rd_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StFill;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            len_q        <= '0;
            frame_last_q <= 1'b0;
            arm_cnt_q    <= '0;
            data_q       <= '0;
            blocks_q     <= '0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            len_q        <= len_d;
            frame_last_q <= frame_last_d;
            arm_cnt_q    <= arm_cnt_d;
            data_q       <= data_d;
            blocks_q     <= blocks_d;
        end
    end

    // Select the output word from the core result. The core holds its result
    // stable until the next start pulse, so it is not registered here.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NW; i++) begin
            if (rd_cnt_q == CW'(i)) begin
                rd_word = chacha_data_out[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        wr_cnt_d          = wr_cnt_q;
        rd_cnt_d          = rd_cnt_q;
        len_d             = len_q;
        frame_last_d      = frame_last_q;
        arm_cnt_d         = arm_cnt_q;
        data_d            = data_q;
        blocks_d          = blocks_q;
        s_axis_tready     = 1'b0;
        m_axis_tvalid     = 1'b0;
        m_axis_tdata      = '0;
        m_axis_tlast      = 1'b0;
        chacha_next_block = 1'b0;

        unique case (state_q)
            StFill: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) begin
                    for (int i = 0; i < NW; i++) begin
                        if (wr_cnt_q == CW'(i)) begin
                            data_d[32*i +: 32] = swap_word(s_axis_tdata);
                        end
                    end
                    wr_cnt_d = wr_cnt_q + CW'(1);
                    if (wr_cnt_q == CW'(NW - 1) || s_axis_tlast) begin
                        len_d        = wr_cnt_q + CW'(1);
                        frame_last_d = s_axis_tlast;
                        state_d      = StStart;
                    end
                end
            end

            StStart: begin
                chacha_next_block = 1'b1;
                arm_cnt_d         = 2'd2;
                state_d           = StArm;
            end

            // The core may still show valid from the previous block here, so
            // chacha_data_valid is deliberately ignored for three cycles.
            StArm: begin
                if (arm_cnt_q == 2'd0) begin
                    state_d = StWait;
                end else begin
                    arm_cnt_d = arm_cnt_q - 2'd1;
                end
            end

            StWait: begin
                if (chacha_data_valid) begin
                    state_d = StDrain;
                end
            end

            StDrain: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = swap_word(rd_word);
                m_axis_tlast  = frame_last_q && (rd_cnt_q == len_q - CW'(1));
                if (m_axis_tready) begin
                    if (rd_cnt_q == len_q - CW'(1)) begin
                        blocks_d = blocks_q + 32'd1;
                        wr_cnt_d = '0;
                        rd_cnt_d = '0;
                        // Clear on re-entry so a short next block is zero-padded.
                        data_d   = '0;
                        state_d  = StFill;
                    end else begin
                        rd_cnt_d = rd_cnt_q + CW'(1);
                    end
                end
            end

            default: begin
                state_d = StFill;
            end
        endcase
    end

    assign chacha_data_in = data_q;
    assign blocks_done    = blocks_q;

endmodule

// File: doc/chacha_stream_adapter.md
# chacha_stream_adapter

AXI-Stream front end that drives `chacha_many`. It packs 32-bit input stream words into a `NUMBER_OF_BLOCKS*512`-bit data block and pulses `chacha_next_block`. It then waits for `chacha_data_valid` and streams the encrypted block back out as 32-bit words. It sits between the AXI DMA stream and the ChaCha core array, handling short final blocks and TLAST.

## Interface
- `NUMBER_OF_BLOCKS`, default 1: ChaCha blocks per transaction; must match the attached `chacha_many`.
- `TOTAL_BIT_WIDTH`, default `NUMBER_OF_BLOCKS*512`: width of the core data buses.
- `clk` input 1: single clock for everything.
- `reset` input 1: synchronous, active-high reset.
- `s_axis_tdata` input 32: plaintext word.
- `s_axis_tvalid` input 1: input word valid.
- `s_axis_tready` output 1: adapter accepts the input word.
- `s_axis_tlast` input 1: last word of the frame.
- `m_axis_tdata` output 32: ciphertext word.
- `m_axis_tvalid` output 1: output word valid.
- `m_axis_tready` input 1: downstream accepts the output word.
- `m_axis_tlast` output 1: last word of the frame.
- `chacha_data_in` output `TOTAL_BIT_WIDTH`: packed block to the core.
- `chacha_next_block` output 1: one-cycle start pulse to the core.
- `chacha_data_out` input `TOTAL_BIT_WIDTH`: core result.
- `chacha_data_valid` input 1: core result valid.
- `blocks_done` output 32: count of completed transactions; wraps at 2^32.

## Operation
- `NW = NUMBER_OF_BLOCKS*16` words per transaction. Word index `i` maps to `chacha_data_in[32*i +: 32]`, and output word `i` is read from `chacha_data_out[32*i +: 32]`.
- State `FILL`:
  - `s_axis_tready` = 1.
  - Each handshake stores the word at index `wr_cnt` and increments `wr_cnt`.
  - Leave `FILL` after word `NW-1` is accepted, or after any accepted word with `tlast=1`. Latch `frame_last` = `tlast` of that word and `len` = number of words accepted.
  - On entry, `chacha_data_in` is cleared to 0, so a short block is zero-padded.
- State `START`: `chacha_next_block` = 1 for exactly one cycle, then go to `ARM`.
- State `ARM`: 3-cycle down-counter. `chacha_data_valid` is ignored here, because the core may still show valid from the previous block. Then go to `WAIT`.
- State `WAIT`: go to `DRAIN` on the first cycle `chacha_data_valid` = 1.
- State `DRAIN`:
  - `m_axis_tvalid` = 1 and `m_axis_tdata` = output word `rd_cnt`.
  - `rd_cnt` advances on `m_axis_tvalid & m_axis_tready`.
  - Only `len` words are emitted; padded words are never output.
  - `m_axis_tlast` = `frame_last & (rd_cnt == len-1)`.
  - After the last word handshake: `blocks_done` += 1, clear `wr_cnt`/`rd_cnt`, go to `FILL`.
- `wr_cnt`/`rd_cnt`/`len` are `$clog2(NW)+1` bits wide.
- `s_axis_tready` is 0 outside `FILL`, and `m_axis_tvalid` is 0 outside `DRAIN`. The adapter never accepts and emits in the same cycle.
- `tlast` on word `NW-1` is a full block with `frame_last` = 1.
- Once asserted, `m_axis_tvalid` and `m_axis_tdata` hold until the handshake (AXI rule). `chacha_data_out` is stable from valid until the next `chacha_next_block`, so no output register is required.

## Timing
- Reset: state `FILL`, all counters 0, `chacha_data_in` = 0, `chacha_next_block` = 0, `m_axis_tvalid` = 0, `m_axis_tlast` = 0, `m_axis_tdata` = 0, `blocks_done` = 0.
- `s_axis_tready` = 1 in the first cycle after reset is released.
- Reset mid-operation aborts any transaction, drops any partial block and returns to `FILL` the next cycle. `chacha_many` must share the reset so its counter restarts.
- `chacha_next_block` is asserted in the cycle after the final input handshake.
- `DRAIN` begins the cycle after `chacha_data_valid` is sampled high in `WAIT`.
- Minimum latency from the last input word to the first output word is 1 (`START`) + 3 (`ARM`) + core latency + 1.
- Throughput: one word per cycle in both `FILL` and `DRAIN`. Backpressure on `m_axis_tready` stalls `DRAIN` indefinitely with no data loss.

## Configuration
- `CHACHA_STREAM_BYTESWAP_EN` defined: every 32-bit word is byte-reversed, `{b0,b1,b2,b3}`, both when written into `chacha_data_in` and when read from `chacha_data_out` onto `m_axis_tdata`. This converts between a big-endian host stream and the core's little-endian words.
- Not defined: words pass through unmodified.

## Test plan
- **Full block, `NUMBER_OF_BLOCKS`=1:**
  - Stimulus: 16 words `0x00000000..0x0000000F` with `tlast` on word 15, then a core model returning `data_in ^ {16{32'hA5A5A5A5}}`.
  - Response: exactly one `next_block` pulse; outputs `0xA5A5A5A5..0xA5A5A5AA`, `tlast` only on word 15; `blocks_done` = 1.
- **Short frame:**
  - Stimulus: 5 words with `tlast` on word 4.
  - Response: `chacha_data_in` words 5..15 = 0; exactly 5 words out, `tlast` on the 5th.
- **Multi-block frame:**
  - Stimulus: 40 words, no `tlast` until word 39.
  - Response: three transactions of 16, 16 and 8 words; `tlast` only on output word 39; `blocks_done` = 3.
- **Stale valid:**
  - Stimulus: core model holds `chacha_data_valid` = 1 through `START`/`ARM`, drops it, then raises it 10 cycles later.
  - Response: `DRAIN` starts only after the re-rise.
- **Backpressure and reset:**
  - Stimulus: toggle `m_axis_tready` 1/0 every cycle, with reset asserted in the middle of `DRAIN`.
  - Response: `tdata` stable while stalled; after reset, `m_axis_tvalid` = 0, `s_axis_tready` = 1, `blocks_done` = 0.
- **Byte swap, built with `CHACHA_STREAM_BYTESWAP_EN`:**
  - Stimulus: input `0x11223344`, identity core model.
  - Response: `chacha_data_in` word 0 = `0x44332211`; output word = `0x11223344`.
